wb_stage_param: RTL and testbench

WB_STAGE_PARAM -- requirements
Module: wb_stage_param

---
 rtl/wb_stage_param.sv | 169 ++++++++++++++++
 tb/tb_wb_stage_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// Writeback staging buffer: computes the register-file result at enqueue time,
// holds up to DEPTH entries in FIFO order and counts retired (dequeued) entries.

module wbResultCalc #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        MemToReg,
  input  logic [2:0]        ExtMode,
  input  logic [1:0]        ByteOff,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic [DATA_W-1:0] ReadReg1,
  input  logic [DATA_W-1:0] Hi,
  input  logic [DATA_W-1:0] Lo,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] sel;
  logic [7:0]        byteV;
  logic [15:0]       halfV;

  always_comb begin
    sel = '0;
    case (MemToReg)
      3'd0: sel = MemReadData;
      3'd1: sel = ALUResult;
      3'd2: sel = PCPlus4;
      3'd3: sel = ReadReg1;
      3'd4: sel = Hi;
      3'd5: sel = Lo;
      default: sel = '0;
    endcase
    // Lanes are taken from the low word only, little-endian.
    byteV = 8'(sel >> {ByteOff, 3'b000});
    halfV = 16'(sel >> {ByteOff[1], 4'b0000});
    result = sel;
    case (ExtMode)
      3'd1: result = {{(DATA_W-16){halfV[15]}}, halfV};
      3'd2: result = {{(DATA_W-8){byteV[7]}}, byteV};
      3'd3: result = {{(DATA_W-16){1'b0}}, halfV};
      3'd4: result = {{(DATA_W-8){1'b0}}, byteV};
      default: result = sel;
    endcase
  end
endmodule

module wb_stage_param #(
  parameter int DATA_W = 32,
  parameter int RAW    = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic                Flush,
  input  logic                RegWriteCtrl,
  input  logic                Move,
  input  logic                Zero,
  input  logic                RegWrite2WB,
  input  logic                HiLoWrite,
  input  logic [2:0]          MemToReg,
  input  logic [2:0]          ExtMode,
  input  logic [1:0]          ByteOff,
  input  logic [DATA_W-1:0]   MemReadData,
  input  logic [DATA_W-1:0]   ALUResult,
  input  logic [DATA_W-1:0]   PCPlus4,
  input  logic [DATA_W-1:0]   ReadReg1,
  input  logic [DATA_W-1:0]   ReadReg2,
  input  logic [DATA_W-1:0]   Hi,
  input  logic [DATA_W-1:0]   Lo,
  input  logic [2*DATA_W-1:0] HiLoResult,
  input  logic [RAW-1:0]      RegDstResult,
  output logic                O_Valid,
  input  logic                O_Ready,
  output logic                oRegWrite1,
  output logic                oRegWrite2WB,
  output logic                oHiLoWrite,
  output logic [DATA_W-1:0]   oRegWriteData,
  output logic [DATA_W-1:0]   oReadReg2,
  output logic [2*DATA_W-1:0] oHiLoResult,
  output logic [RAW-1:0]      oRegDstResult,
  output logic [CNT_W-1:0]    oRetired
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                regWrite1;
    logic                regWrite2WB;
    logic                hiLoWrite;
    logic [DATA_W-1:0]   data;
    logic [DATA_W-1:0]   readReg2;
    logic [2*DATA_W-1:0] hiLo;
    logic [RAW-1:0]      rd;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            newEntry, head;
  logic [PW-1:0]     headPtr, tailPtr;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  retired;
  logic [DATA_W-1:0] result;
  logic              enq, deq;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  wbResultCalc #(.DATA_W(DATA_W)) uCalc (
    .MemToReg(MemToReg), .ExtMode(ExtMode), .ByteOff(ByteOff),
    .MemReadData(MemReadData), .ALUResult(ALUResult), .PCPlus4(PCPlus4),
    .ReadReg1(ReadReg1), .Hi(Hi), .Lo(Lo), .result(result)
  );

  assign In_Ready = (count < CW'(DEPTH));
  assign O_Valid  = (count != '0);
  assign enq      = In_Valid & In_Ready & ~Flush;
  assign deq      = O_Valid & O_Ready & ~Flush;

  always_comb begin
    newEntry             = '0;
    // Writes to r0 are squashed here so the head never advertises them.
    newEntry.regWrite1   = (RegWriteCtrl | (Move & Zero) | RegWrite2WB) & (RegDstResult != '0);
    newEntry.regWrite2WB = RegWrite2WB;
    newEntry.hiLoWrite   = HiLoWrite;
    newEntry.data        = result;
    newEntry.readReg2    = ReadReg2;
    newEntry.hiLo        = HiLoResult;
    newEntry.rd          = RegDstResult;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      retired <= '0;
    end else if (Flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (enq) begin
        mem[tailPtr] <= newEntry;
        tailPtr      <= nextPtr(tailPtr);
      end
      if (deq) begin
        headPtr <= nextPtr(headPtr);
        retired <= retired + 1'b1;
      end
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  // Outputs are gated by O_Valid so an empty buffer shows all zeros.
  assign head          = O_Valid ? mem[headPtr] : '0;
  assign oRegWrite1    = head.regWrite1;
  assign oRegWrite2WB  = head.regWrite2WB;
  assign oHiLoWrite    = head.hiLoWrite;
  assign oRegWriteData = head.data;
  assign oReadReg2     = head.readReg2;
  assign oHiLoResult   = head.hiLo;
  assign oRegDstResult = head.rd;
  assign oRetired      = retired;
endmodule

// File: tb/tb_wb_stage_param.sv
// Directed bench for wb_stage_param: a 32-bit DEPTH=2 instance for flow/result
// checks and a 64-bit instance for wide lane extraction.

module tb_wb_stage_param;
  logic        Clk = 0, Reset = 1, In_Valid = 0, Flush = 0, O_Ready = 0;
  logic        RegWriteCtrl = 0, Move = 0, Zero = 0, RegWrite2WB = 0, HiLoWrite = 0;
  logic [2:0]  MemToReg = 0, ExtMode = 0;
  logic [1:0]  ByteOff = 0;
  logic [31:0] MemReadData = 0, ALUResult = 0, PCPlus4 = 0, ReadReg1 = 0, ReadReg2 = 0, Hi = 0, Lo = 0;
  logic [63:0] HiLoResult = 0;
  logic [4:0]  Rd = 0;
  logic        In_Ready, O_Valid, oRegWrite1, oRegWrite2WB, oHiLoWrite;
  logic [31:0] oRegWriteData, oReadReg2;
  logic [63:0] oHiLoResult;
  logic [4:0]  oRegDstResult;
  logic [15:0] oRetired;

  logic        v64 = 0, r64 = 0;
  logic [63:0] mrd64 = 0;
  logic        inReady64, oValid64, w1_64, w2_64, hl64;
  logic [63:0] data64, rr2_64;
  logic [127:0] hilo64;
  logic [4:0]  rd64;
  logic [15:0] ret64;

  int checks = 0, failures = 0;
  int expRet = 0;

  always #5 Clk = ~Clk;

  wb_stage_param #(.DATA_W(32), .RAW(5), .DEPTH(2), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready), .Flush(Flush),
    .RegWriteCtrl(RegWriteCtrl), .Move(Move), .Zero(Zero), .RegWrite2WB(RegWrite2WB),
    .HiLoWrite(HiLoWrite), .MemToReg(MemToReg), .ExtMode(ExtMode), .ByteOff(ByteOff),
    .MemReadData(MemReadData), .ALUResult(ALUResult), .PCPlus4(PCPlus4), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .Hi(Hi), .Lo(Lo), .HiLoResult(HiLoResult), .RegDstResult(Rd),
    .O_Valid(O_Valid), .O_Ready(O_Ready), .oRegWrite1(oRegWrite1), .oRegWrite2WB(oRegWrite2WB),
    .oHiLoWrite(oHiLoWrite), .oRegWriteData(oRegWriteData), .oReadReg2(oReadReg2),
    .oHiLoResult(oHiLoResult), .oRegDstResult(oRegDstResult), .oRetired(oRetired)
  );

  wb_stage_param #(.DATA_W(64), .RAW(5), .DEPTH(2), .CNT_W(16)) dut64 (
    .Clk(Clk), .Reset(Reset), .In_Valid(v64), .In_Ready(inReady64), .Flush(Flush),
    .RegWriteCtrl(RegWriteCtrl), .Move(Move), .Zero(Zero), .RegWrite2WB(RegWrite2WB),
    .HiLoWrite(HiLoWrite), .MemToReg(MemToReg), .ExtMode(ExtMode), .ByteOff(ByteOff),
    .MemReadData(mrd64), .ALUResult({32'h0, ALUResult}), .PCPlus4({32'h0, PCPlus4}),
    .ReadReg1({32'h0, ReadReg1}), .ReadReg2({32'h0, ReadReg2}), .Hi({32'h0, Hi}),
    .Lo({32'h0, Lo}), .HiLoResult({64'h0, HiLoResult}), .RegDstResult(Rd),
    .O_Valid(oValid64), .O_Ready(r64), .oRegWrite1(w1_64), .oRegWrite2WB(w2_64),
    .oHiLoWrite(hl64), .oRegWriteData(data64), .oReadReg2(rr2_64),
    .oHiLoResult(hilo64), .oRegDstResult(rd64), .oRetired(ret64)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic enq1();
    In_Valid = 1;
    tick();
    In_Valid = 0;
  endtask

  task automatic deq1();
    O_Ready = 1;
    tick();
    O_Ready = 0;
    expRet++;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  ext;
    logic [1:0]  off;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [11];

  initial begin
    vt[0]  = '{3'd0, 3'd0, 2'd0, 32'h12F34567};
    vt[1]  = '{3'd1, 3'd1, 2'd0, 32'hFFFF8001};
    vt[2]  = '{3'd1, 3'd3, 2'd2, 32'h0000A5A5};
    vt[3]  = '{3'd2, 3'd0, 2'd0, 32'h00001004};
    vt[4]  = '{3'd3, 3'd4, 2'd3, 32'h000000AB};
    vt[5]  = '{3'd3, 3'd2, 2'd3, 32'hFFFFFFAB};
    vt[6]  = '{3'd4, 3'd0, 2'd0, 32'h11112222};
    vt[7]  = '{3'd5, 3'd7, 2'd1, 32'h33334444};
    vt[8]  = '{3'd6, 3'd0, 2'd0, 32'h00000000};
    vt[9]  = '{3'd0, 3'd1, 2'd1, 32'h00004567};
    vt[10] = '{3'd0, 3'd4, 2'd1, 32'h00000045};

    // reset state
    #2;
    chk("rst_ovalid", O_Valid, 0);
    chk("rst_inready", In_Ready, 1);
    chk("rst_retired", oRetired, 0);
    chk("rst_data", oRegWriteData, 0);
    chk("rst_we", {oRegWrite1, oRegWrite2WB, oHiLoWrite}, 0);
    chk("rst_hilo", oHiLoResult, 0);
    tick();
    Reset = 0;
    tick();

    // 64-bit zero-extended half from upper lane
    ExtMode = 3; ByteOff = 2; MemToReg = 0; mrd64 = 64'h0000_0000_8001_0000;
    v64 = 1; tick(); v64 = 0;
    chk("w64_valid", oValid64, 1);
    chk("w64_data", data64, 64'h0000_0000_0000_8001);

    // sign-extended byte from lane 2
    MemToReg = 0; ExtMode = 2; ByteOff = 2; MemReadData = 32'h12F34567;
    RegWriteCtrl = 1; Rd = 5;
    enq1();
    chk("sxb_valid", O_Valid, 1);
    chk("sxb_data", oRegWriteData, 32'hFFFFFFF3);
    chk("sxb_we1", oRegWrite1, 1);
    chk("sxb_rd", oRegDstResult, 5);
    deq1();
    chk("sxb_retired", oRetired, expRet);
    chk("sxb_empty", O_Valid, 0);

    // move-conditional writes and r0 squash
    RegWriteCtrl = 0; Move = 1; Zero = 1; Rd = 0;
    enq1(); chk("mov_rd0", oRegWrite1, 0); deq1();
    Rd = 9;
    enq1(); chk("mov_rd9", oRegWrite1, 1); deq1();
    Zero = 0;
    enq1(); chk("mov_z0", oRegWrite1, 0); deq1();
    Move = 0;

    // side-band fields and RegWrite2WB to r0
    RegWrite2WB = 1; HiLoWrite = 1; Rd = 0; ReadReg2 = 32'hCAFE0001;
    HiLoResult = 64'h0123_4567_89AB_CDEF;
    enq1();
    chk("wb2_we1", oRegWrite1, 0);
    chk("wb2_we2", oRegWrite2WB, 1);
    chk("wb2_hlw", oHiLoWrite, 1);
    chk("wb2_rr2", oReadReg2, 32'hCAFE0001);
    chk("wb2_hilo", oHiLoResult, 64'h0123_4567_89AB_CDEF);
    deq1();
    chk("wb2_off", {oRegWrite1, oRegWrite2WB, oHiLoWrite}, 0);
    RegWrite2WB = 0; HiLoWrite = 0; Rd = 3;

    // result mux / extension table
    MemReadData = 32'h12F34567; ALUResult = 32'hA5A58001; PCPlus4 = 32'h00001004;
    ReadReg1 = 32'hAB000000; Hi = 32'h11112222; Lo = 32'h33334444;
    for (int i = 0; i < 11; i++) begin
      MemToReg = vt[i].sel; ExtMode = vt[i].ext; ByteOff = vt[i].off;
      enq1();
      chk($sformatf("mux%0d", i), oRegWriteData, vt[i].exp);
      deq1();
    end

    // backpressure: fill, hold third upstream, then drain
    MemToReg = 1; ExtMode = 0; ByteOff = 0;
    In_Valid = 1; ALUResult = 1; tick();
    chk("bp_ready1", In_Ready, 1);
    ALUResult = 2; tick();
    chk("bp_full", In_Ready, 0);
    chk("bp_head1", oRegWriteData, 1);
    ALUResult = 3; tick();
    chk("bp_hold", oRegWriteData, 1);
    chk("bp_full2", In_Ready, 0);
    O_Ready = 1; tick(); expRet++;
    chk("bp_head2", oRegWriteData, 2);
    chk("bp_ready2", In_Ready, 1);
    tick(); expRet++;
    In_Valid = 0;
    chk("bp_head3", oRegWriteData, 3);
    tick(); expRet++;
    O_Ready = 0;
    chk("bp_empty", O_Valid, 0);
    chk("bp_retired", oRetired, expRet);

    // simultaneous enq/deq at count=1, then flush
    ALUResult = 10; enq1();
    ALUResult = 11; In_Valid = 1; O_Ready = 1; tick(); expRet++;
    In_Valid = 0; O_Ready = 0;
    chk("sim_valid", O_Valid, 1);
    chk("sim_ready", In_Ready, 1);
    chk("sim_head", oRegWriteData, 11);
    chk("sim_retired", oRetired, expRet);
    Flush = 1; In_Valid = 1; O_Ready = 1; tick();
    Flush = 0; In_Valid = 0; O_Ready = 0;
    chk("fl_valid", O_Valid, 0);
    chk("fl_ready", In_Ready, 1);
    chk("fl_retired", oRetired, expRet);

    // async reset between edges with a full buffer
    ALUResult = 20; enq1();
    ALUResult = 21; enq1();
    chk("ar_full", In_Ready, 0);
    #1 Reset = 1;
    #1;
    chk("ar_valid", O_Valid, 0);
    chk("ar_ready", In_Ready, 1);
    chk("ar_retired", oRetired, 0);
    Reset = 0; expRet = 0;
    ALUResult = 30; enq1();
    chk("ar_head", oRegWriteData, 30);
    deq1();
    chk("ar_retired1", oRetired, expRet);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
